// File: rtl/vert_motion.sv
`default_nettype none
// ============================================================================
// Module      : vert_motion
// Description : Per-frame vertical motion controller for a platformer sprite.
//               Integrates gravity, handles jumps (multi-jump per grounding),
//               landing on a platform or the stage floor, walking off an
//               edge and a ceiling clamp at y = 0.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               frame_tick           - one-cycle pulse per video frame
//               jump_btn             - debounced jump button level
//               touching_platform    - platform crossing flag (uses y_pos/next_y)
//               y_pos      [9:0]     - registered top-of-sprite y
//               next_y     [9:0]     - combinational candidate y for this frame
//               vel_y      [5:0]     - registered signed velocity (+ = down)
//               state      [1:0]     - 0 GROUNDED, 1 RISING, 2 FALLING
//               grounded             - state == GROUNDED
//               jumps_left [1:0]     - remaining jumps
// Revision    : 1.0 - initial release
// ============================================================================
module vert_motion #(
    parameter int HEIGHT     = 30,
    parameter int GRAVITY    = 1,
    parameter int JUMP_VEL   = 12,
    parameter int MAX_FALL   = 8,
    parameter int MAX_JUMPS  = 2,
    parameter int SPAWN_Y    = 100,
    parameter int PLATFORM_Y = 215,
    parameter int FLOOR_Y    = 420
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       jump_btn,
    input  logic       touching_platform,
    output logic [9:0] y_pos,
    output logic [9:0] next_y,
    output logic [5:0] vel_y,
    output logic [1:0] state,
    output logic       grounded,
    output logic [1:0] jumps_left
);

    typedef enum logic [1:0] {
        c_grounded = 2'd0,
        c_rising   = 2'd1,
        c_falling  = 2'd2
    } state_t;

    localparam logic [9:0]        c_land_y    = 10'(PLATFORM_Y - 2*HEIGHT);
    localparam logic [9:0]        c_flr_y     = 10'(FLOOR_Y - 2*HEIGHT);
    localparam logic [9:0]        c_spawn_y   = 10'(SPAWN_Y);
    localparam logic [5:0]        c_jump_v    = 6'(-JUMP_VEL);
    localparam logic [5:0]        c_grav_v    = 6'(GRAVITY);
    localparam logic signed [6:0] c_grav_w    = 7'(GRAVITY);
    localparam logic signed [6:0] c_maxfall_w = 7'(MAX_FALL);
    localparam logic [5:0]        c_maxfall_v = 6'(MAX_FALL);
    localparam logic [1:0]        c_jumps     = 2'(MAX_JUMPS);
    localparam logic [1:0]        c_jumps_m1  = 2'(MAX_JUMPS - 1);

    state_t             r_state;
    logic               r_btn_d;
    logic               r_jump_pend;

    logic               w_rise;
    logic               w_jump_req;
    logic signed [10:0] w_sum;
    logic signed [6:0]  w_vel_inc;
    logic [5:0]         w_vel_new;

    // Button edge detect; an edge landing on a tick cycle is used directly by
    // that tick instead of being latched for the following frame.
    assign w_rise     = jump_btn & ~r_btn_d;
    assign w_jump_req = r_jump_pend | w_rise;

    // 11-bit signed sum so a negative result (ceiling hit) is detectable.
    assign w_sum  = $signed({1'b0, y_pos}) + $signed({{5{vel_y[5]}}, vel_y});
    assign next_y = w_sum[10] ? 10'd0 : w_sum[9:0];

    // Gravity with terminal-velocity cap.
    assign w_vel_inc = $signed({vel_y[5], vel_y}) + c_grav_w;
    assign w_vel_new = (w_vel_inc > c_maxfall_w) ? c_maxfall_v : w_vel_inc[5:0];

    assign state    = r_state;
    assign grounded = (r_state == c_grounded);

    // Jump request latch: held until the next tick, cleared on every tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_d     <= 1'b0;
            r_jump_pend <= 1'b0;
        end else begin
            r_btn_d <= jump_btn;
            if (frame_tick) begin
                r_jump_pend <= 1'b0;
            end else if (w_rise) begin
                r_jump_pend <= 1'b1;
            end
        end
    end

    // Motion state machine; rules are evaluated in priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_pos      <= c_spawn_y;
            vel_y      <= 6'd0;
            r_state    <= c_falling;
            jumps_left <= c_jumps;
        end else if (frame_tick) begin
            if (w_jump_req && (jumps_left != 2'd0)) begin
                // Jump wins over any landing on the same frame.
                vel_y      <= c_jump_v;
                r_state    <= c_rising;
                jumps_left <= jumps_left - 2'd1;
            end else if ((r_state != c_grounded) && !vel_y[5] && touching_platform) begin
                y_pos      <= c_land_y;
                vel_y      <= 6'd0;
                r_state    <= c_grounded;
                jumps_left <= c_jumps;
            end else if ((r_state != c_grounded) && (next_y >= c_flr_y)) begin
                y_pos      <= c_flr_y;
                vel_y      <= 6'd0;
                r_state    <= c_grounded;
                jumps_left <= c_jumps;
            end else if (r_state == c_grounded) begin
                // Walked off the platform edge: one jump is spent by leaving
                // the ground without jumping.
                if (!touching_platform && (y_pos != c_flr_y)) begin
                    r_state    <= c_falling;
                    vel_y      <= c_grav_v;
                    jumps_left <= c_jumps_m1;
                end
            end else begin
                if (w_sum[10]) begin
                    // Head hit the top of the screen: stop and start falling.
                    y_pos   <= 10'd0;
                    vel_y   <= 6'd0;
                    r_state <= c_falling;
                end else begin
                    y_pos   <= next_y;
                    vel_y   <= w_vel_new;
                    r_state <= w_vel_new[5] ? c_rising : c_falling;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vert_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_vert_motion
// Description : Directed self-checking bench for vert_motion with
//               hand-computed expected positions, velocities and states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vert_motion;

    localparam int c_gnd = 0;
    localparam int c_ris = 1;
    localparam int c_fal = 2;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       jump_btn;
    logic       touching_platform;
    logic [9:0] y_pos;
    logic [9:0] next_y;
    logic [5:0] vel_y;
    logic [1:0] state;
    logic       grounded;
    logic [1:0] jumps_left;

    int r_checks;
    int r_errors;

    vert_motion dut (
        .clk               (clk),
        .rst               (rst),
        .frame_tick        (frame_tick),
        .jump_btn          (jump_btn),
        .touching_platform (touching_platform),
        .y_pos             (y_pos),
        .next_y            (next_y),
        .vel_y             (vel_y),
        .state             (state),
        .grounded          (grounded),
        .jumps_left        (jumps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int y, input int v,
                             input int st, input int jl);
        check({tag, ".y"},     int'(y_pos), y);
        check({tag, ".vel"},   int'($signed(vel_y)), v);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".jumps"}, int'(jumps_left), jl);
    endtask

    // One frame tick; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic touch);
        @(negedge clk);
        touching_platform = touch;
        frame_tick        = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic touch);
        for (int i = 0; i < n; i++) tick(touch);
    endtask

    // One-cycle button pulse between ticks.
    task automatic press();
        @(negedge clk);
        jump_btn = 1'b1;
        @(negedge clk);
        jump_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fall from spawn: 11 ticks reach y=152 vel=8, the 12th lands on 155.
    task automatic land_on_platform();
        do_reset();
        ticks(11, 1'b0);
        tick(1'b1);
    endtask

    initial begin
        r_checks          = 0;
        r_errors          = 0;
        rst               = 1'b1;
        frame_tick        = 1'b0;
        jump_btn          = 1'b0;
        touching_platform = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 100, 0, c_fal, 2);
        check("reset.next_y", int'(next_y), 100);
        check("reset.grounded", int'(grounded), 0);
        rst = 1'b0;

        // Free fall from spawn.
        tick(1'b0); check_all("fall1", 100, 1, c_fal, 2);
        tick(1'b0); check_all("fall2", 101, 2, c_fal, 2);
        tick(1'b0); check_all("fall3", 103, 3, c_fal, 2);
        // Registered outputs hold between ticks.
        repeat (4) @(posedge clk);
        #1;
        check_all("hold", 103, 3, c_fal, 2);

        // Landing on the platform.
        land_on_platform();
        check_all("land", 155, 0, c_gnd, 2);
        check("land.grounded", int'(grounded), 1);

        // Double jump, third press ignored.
        press(); tick(1'b1); check_all("jump1", 155, -12, c_ris, 1);
        tick(1'b0);          check_all("rise1", 143, -11, c_ris, 1);
        press(); tick(1'b0); check_all("jump2", 143, -12, c_ris, 0);
        press(); tick(1'b0); check_all("jump3ign", 131, -11, c_ris, 0);

        // Walk off the platform edge.
        land_on_platform();
        tick(1'b0); check_all("walkoff", 155, 1, c_fal, 1);
        tick(1'b0); check_all("walkoff2", 156, 2, c_fal, 1);

        // Jump has priority over landing on the same tick.
        do_reset();
        ticks(11, 1'b0);
        check_all("pre_prio", 152, 8, c_fal, 2);
        press(); tick(1'b1); check_all("prio", 152, -12, c_ris, 1);

        // Fall to the floor; y(k) = 128 + 8*(k-8) for k >= 8, k=37 lands.
        do_reset();
        ticks(36, 1'b0);
        check_all("pre_floor", 352, 8, c_fal, 2);
        tick(1'b0); check_all("floor", 360, 0, c_gnd, 2);
        tick(1'b0); check_all("floor_stay", 360, 0, c_gnd, 2);

        // Button edge on the tick cycle itself is consumed by that tick.
        @(negedge clk);
        jump_btn          = 1'b1;
        touching_platform = 1'b0;
        frame_tick        = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check_all("edge_on_tick", 360, -12, c_ris, 1);
        // Held button gives no new edge; rising so no platform landing.
        tick(1'b1); check_all("held", 348, -11, c_ris, 1);
        @(negedge clk);
        jump_btn = 1'b0;

        // Latched press survives idle cycles, then is cleared by the tick.
        press();
        repeat (3) @(posedge clk);
        #1;
        check_all("latch_hold", 348, -11, c_ris, 1);
        tick(1'b0); check_all("latched", 348, -12, c_ris, 0);
        tick(1'b0); check_all("latch_clr", 336, -11, c_ris, 0);

        // Reset mid-rise, colliding with a tick and a button edge.
        @(negedge clk);
        rst        = 1'b1;
        frame_tick = 1'b1;
        jump_btn   = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        frame_tick = 1'b0;
        jump_btn   = 1'b0;
        check_all("rst_mid", 100, 0, c_fal, 2);
        tick(1'b0); check_all("rst_first", 100, 1, c_fal, 2);

        // Ceiling clamp via a double jump from spawn.
        do_reset();
        press(); tick(1'b0); check_all("c_jump1", 100, -12, c_ris, 1);
        ticks(10, 1'b0);     check_all("c_rise", 25, -2, c_ris, 1);
        press(); tick(1'b0); check_all("c_jump2", 25, -12, c_ris, 0);
        tick(1'b0);          check_all("c_r1", 13, -11, c_ris, 0);
        tick(1'b0);          check_all("c_r2", 2, -10, c_ris, 0);
        check("c_next_y_clamp", int'(next_y), 0);
        tick(1'b0);          check_all("ceiling", 0, 0, c_fal, 0);
        press(); tick(1'b0); check_all("nojumps", 0, 1, c_fal, 0);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
